// File: rtl/tpu_pkg.sv
// Shared Mini-TPU definitions.
//   feed_state_t : feed sequencer state encoding
//   DATA_WIDTH   : default operand element width in bits
//   SIZE         : default array dimension (lines, columns, elements per line)
package tpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int SIZE       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } feed_state_t;

endpackage

// File: rtl/skew_decode.sv
// Diagonal wavefront decoder: maps the pass cycle counter t to per-column
// read enables and element selects. Column c is live for t in [c, c+SIZE-1]
// and reads element t-c; idle columns drive select 0.
//   active  : in  decode enabled (all outputs zero when low)
//   t       : in  pass cycle counter
//   rd_en   : out per-column enable, bit c = column c
//   rd_elem : out per-column element select, column c at [c*ELEM_W +: ELEM_W]
module skew_decode #(
  parameter int SIZE   = 4,
  parameter int ELEM_W = $clog2(SIZE),
  parameter int T_W    = $clog2(2*SIZE-1)
) (
  input  logic                   active,
  input  logic [T_W-1:0]         t,
  output logic [SIZE-1:0]        rd_en,
  output logic [SIZE*ELEM_W-1:0] rd_elem
);

  int t_int;

  always_comb begin
    rd_en   = '0;
    rd_elem = '0;
    t_int   = int'(t);
    if (active) begin
      for (int c = 0; c < SIZE; c++) begin
        if ((t_int >= c) && (t_int <= c + SIZE - 1)) begin
          rd_en[c]                     = 1'b1;
          rd_elem[c*ELEM_W +: ELEM_W]  = ELEM_W'(t_int - c);
        end
      end
    end
  end

endmodule

// File: rtl/feed_scheduler.sv
// Operand feed sequencer for the Mini-TPU. Forwards host element writes to
// the operand memory while idle, and on start drives a diagonally skewed
// read wavefront so the systolic array sees column c delayed by c cycles.
//   clk, rst_n              : clock, async active-low reset
//   start                   : in  request one feed pass (IDLE only)
//   busy, done, feed_last   : out pass status (done is a one-cycle pulse)
//   load_valid/ready        : host write handshake
//   load_line/elem/data     : host write address and data
//   mem_wr_*                : operand memory write port
//   mem_rd_en, mem_rd_elem  : operand memory per-column read controls
//
// state | meaning
// IDLE  | accepting host writes, waiting for start
// FEED  | wavefront in progress, t = 0 .. 2*SIZE-2
// DONE  | one-cycle completion pulse, no reads
module feed_scheduler
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
  parameter int SIZE       = tpu_pkg::SIZE,
  parameter int ELEM_W     = $clog2(SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [ELEM_W-1:0]      load_line,
  input  logic [ELEM_W-1:0]      load_elem,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   mem_wr_en,
  output logic [ELEM_W-1:0]      mem_wr_line,
  output logic [ELEM_W-1:0]      mem_wr_elem,
  output logic [DATA_WIDTH-1:0]  mem_wr_data,
  output logic [SIZE-1:0]        mem_rd_en,
  output logic [SIZE*ELEM_W-1:0] mem_rd_elem,
  output logic                   feed_last
);

  localparam int             T_W    = $clog2(2*SIZE-1);
  localparam logic [T_W-1:0] T_LAST = T_W'(2*SIZE-2);

  feed_state_t    state_q, state_d;
  logic [T_W-1:0] t_q, t_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          t_d     = '0;
        end
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q == FEED) || (state_q == DONE);
  assign done        = (state_q == DONE);
  assign feed_last   = (state_q == FEED) && (t_q == T_LAST);

  assign mem_wr_en   = load_valid & load_ready;
  assign mem_wr_line = load_line;
  assign mem_wr_elem = load_elem;
  assign mem_wr_data = load_data;

  skew_decode #(
    .SIZE   (SIZE),
    .ELEM_W (ELEM_W),
    .T_W    (T_W)
  ) u_skew_decode (
    .active  (state_q == FEED),
    .t       (t_q),
    .rd_en   (mem_rd_en),
    .rd_elem (mem_rd_elem)
  );

endmodule
